// File: rtl/mem_block_arbiter_pkg.sv
// Shared widths, state encoding and requester ids for the memory block arbiter.
package mem_block_arbiter_pkg;

   localparam int addr = 32;
   localparam int ofst = 5;
   localparam int blck = 8 << ofst;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } req_id_t;

   function automatic logic [addr-1:0] block_align(input logic [addr-1:0] a);
      return {a[addr-1:ofst], {ofst{1'b0}}};
   endfunction

endpackage

// File: rtl/mem_block_arbiter_if.sv
// Main-memory block port: one request held until a single-cycle ack.
interface mem_block_arbiter_if;
   import mem_block_arbiter_pkg::*;

   logic            mem_req;
   logic            mem_we;
   logic [addr-1:0] mem_addr;
   logic [blck-1:0] mem_wdata;
   logic [blck-1:0] mem_rdata;
   logic            mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata,
      output mem_ack
   );

endinterface

// File: rtl/mem_block_arbiter_arb_req_latch.sv
// Per-requester capture of a one-cycle block request pulse, with sticky overrun
// for pulses that arrive while a request is still pending or in service.
module arb_req_latch
   import mem_block_arbiter_pkg::*;
(
   input  logic            CLK,
   input  logic            RESET,
   input  logic            rd_pulse,
   input  logic            wr_pulse,
   input  logic [addr-1:0] req_addr,
   input  logic [blck-1:0] req_wdata,
   input  logic            cancel,
   input  logic            busy,
   input  logic            take,
   output logic            pending,
   output logic [addr-1:0] lat_addr,
   output logic [blck-1:0] lat_wdata,
   output logic            lat_we,
   output logic            overrun
);

   logic pulse;
   logic accept;
   logic dropped;

   // A cancelled pulse is discarded silently; it is not an overrun.
   assign pulse   = rd_pulse | wr_pulse;
   assign accept  = pulse & ~cancel & ~pending & ~busy;
   assign dropped = pulse & ~cancel & (pending | busy | (rd_pulse & wr_pulse));

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         pending   <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_we    <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         pending <= accept | (pending & ~take & ~cancel);
         if (accept) begin
            lat_addr <= req_addr;
            lat_we   <= wr_pulse;
            if (wr_pulse) begin
               lat_wdata <= req_wdata;
            end
         end
         if (dropped) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_block_arbiter.sv
// Round-robin arbiter sharing one memory block port between I$ fills and
// D$ fills/write-backs, with mispredict cancellation of I$ fills.
module mem_block_arbiter
   import mem_block_arbiter_pkg::*;
(
   input  logic                CLK,
   input  logic                RESET,
   input  logic                mispredict,
   input  logic                i_bread,
   input  logic [addr-1:0]     i_addr,
   output logic [blck-1:0]     i_block,
   output logic                i_done,
   input  logic                d_bread,
   input  logic                d_bwrite,
   input  logic [addr-1:0]     d_addr,
   input  logic [blck-1:0]     d_wblock,
   output logic [blck-1:0]     d_block,
   output logic                d_done,
   mem_block_arbiter_if.master mem,
   output logic                overrun
);

   state_t          state, next_state;
   req_id_t         grant, next_grant, last_grant;
   logic            discard;
   logic            i_pending, d_pending, i_elig;
   logic            i_busy, d_busy, i_take, d_take;
   logic            i_ovr, d_ovr;
   logic [addr-1:0] i_lat_addr, d_lat_addr;
   logic [blck-1:0] i_lat_wdata, d_lat_wdata;
   logic            i_lat_we, d_lat_we;
   logic            mem_req_c, mem_we_q;
   logic [addr-1:0] mem_addr_q;
   logic [blck-1:0] mem_wdata_q;

   // A fill being discarded no longer blocks a fresh I$ request.
   assign i_elig  = i_pending & ~mispredict;
   assign i_busy  = (state != IDLE) && (grant == REQ_I) && !discard;
   assign d_busy  = (state != IDLE) && (grant == REQ_D);
   assign overrun = i_ovr | d_ovr;

   arb_req_latch u_i_latch (
      .CLK       (CLK),
      .RESET     (RESET),
      .rd_pulse  (i_bread),
      .wr_pulse  (1'b0),
      .req_addr  (i_addr),
      .req_wdata ({blck{1'b0}}),
      .cancel    (mispredict),
      .busy      (i_busy),
      .take      (i_take),
      .pending   (i_pending),
      .lat_addr  (i_lat_addr),
      .lat_wdata (i_lat_wdata),
      .lat_we    (i_lat_we),
      .overrun   (i_ovr)
   );

   arb_req_latch u_d_latch (
      .CLK       (CLK),
      .RESET     (RESET),
      .rd_pulse  (d_bread),
      .wr_pulse  (d_bwrite),
      .req_addr  (d_addr),
      .req_wdata (d_wblock),
      .cancel    (1'b0),
      .busy      (d_busy),
      .take      (d_take),
      .pending   (d_pending),
      .lat_addr  (d_lat_addr),
      .lat_wdata (d_lat_wdata),
      .lat_we    (d_lat_we),
      .overrun   (d_ovr)
   );

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state      <= IDLE;
         grant      <= REQ_I;
         last_grant <= REQ_I;
      end else begin
         state <= next_state;
         grant <= next_grant;
         if (i_take || d_take) begin
            last_grant <= next_grant;
         end
      end
   end

   always_comb begin
      next_state = state;
      next_grant = grant;
      i_take     = 1'b0;
      d_take     = 1'b0;
      mem_req_c  = 1'b0;
      case (state)
         IDLE: begin
            if (i_elig || d_pending) begin
               if (i_elig && d_pending) begin
                  next_grant = (last_grant == REQ_I) ? REQ_D : REQ_I;
               end else begin
                  next_grant = d_pending ? REQ_D : REQ_I;
               end
               i_take     = (next_grant == REQ_I);
               d_take     = (next_grant == REQ_D);
               next_state = BUSY;
            end
         end
         BUSY: begin
            mem_req_c = 1'b1;
            if (mem.mem_ack) begin
               next_state = RESP;
            end
         end
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Done is registered out of RESP, so it lands one cycle after the ack capture.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_block     <= '0;
         d_block     <= '0;
         i_done      <= 1'b0;
         d_done      <= 1'b0;
         discard     <= 1'b0;
      end else begin
         i_done <= 1'b0;
         d_done <= 1'b0;
         if (i_take || d_take) begin
            mem_addr_q  <= block_align(d_take ? d_lat_addr : i_lat_addr);
            mem_we_q    <= d_take ? d_lat_we : i_lat_we;
            mem_wdata_q <= d_take ? d_lat_wdata : i_lat_wdata;
         end
         if (state == BUSY && grant == REQ_I && mispredict) begin
            discard <= 1'b1;
         end
         if (state == BUSY && mem.mem_ack) begin
            if (grant == REQ_D) begin
               if (!mem_we_q) begin
                  d_block <= mem.mem_rdata;
               end
            end else if (!discard && !mispredict) begin
               i_block <= mem.mem_rdata;
            end
         end
         if (state == RESP) begin
            discard <= 1'b0;
            if (grant == REQ_D) begin
               d_done <= 1'b1;
            end else begin
               i_done <= !discard;
            end
         end
      end
   end

   assign mem.mem_req   = mem_req_c;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_block_arbiter.md
Name: mem_block_arbiter

Overview:
- Shares one main-memory block port between the instruction cache (block reads only) and the data cache (block reads and write-backs).
- Latches the caches' one-cycle bread/bwrite pulses and arbitrates round-robin between them.
- Sequences one memory transaction at a time and returns read blocks with a one-cycle done pulse.
- Handles I-fetch cancellation on mispredict so that stale blocks are never delivered.

Parameters:
- addr, 32, address width.
- ofst, 5, block offset bits; memory addresses are block-aligned.
- blck, 8<<ofst (256), block width in bits.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous reset, active-low.
- mispredict  in  1  cancels any pending or in-flight I$ fill.
- i_bread  in  1  I$ block-read request pulse.
- i_addr  in  addr  I$ request address, sampled with i_bread.
- i_block  out  blck  read block returned to I$.
- i_done  out  1  one-cycle pulse; i_block is valid this cycle.
- d_bread  in  1  D$ block-read request pulse.
- d_bwrite  in  1  D$ write-back request pulse.
- d_addr  in  addr  D$ request address, sampled with d_bread or d_bwrite.
- d_wblock  in  blck  write-back data, sampled with d_bwrite.
- d_block  out  blck  read block returned to D$.
- d_done  out  1  one-cycle pulse; completes a D$ read or write.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write, 0 = read; stable while mem_req is high.
- mem_addr  out  addr  request address with the low ofst bits forced to 0.
- mem_wdata  out  blck  write data.
- mem_rdata  in  blck  read data, valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle transaction-complete pulse.
- overrun  out  1  sticky flag: a request was dropped; cleared only by reset.

Behaviour:
- Reset (RESET low, asynchronous):
  - State goes to IDLE; both pending bits clear; last_grant = I (so D$ wins the first tie).
  - Discard flag clears; overrun clears.
  - mem_req, mem_we, i_done and d_done are 0; mem_addr, mem_wdata, i_block and d_block are 0.
- Request capture (rising edge):
  - A pulse sets the requester's pending bit and latches its address, plus the write data and read/write kind for D$.
  - A pulse from a requester whose request is already pending or in service is dropped and sets overrun.
  - d_bread and d_bwrite high in the same cycle: the write is taken, the read is dropped, overrun is set.
- State machine IDLE -> BUSY -> RESP -> IDLE:
  - IDLE: if any request is pending, grant it. If both are pending, grant the requester not equal to last_grant. Clear the granted pending bit, update last_grant, load the mem_* registers, and go to BUSY.
  - BUSY: mem_req = 1 with address and data held constant. On mem_ack, register mem_rdata into the granted requester's block output and go to RESP.
  - RESP: assert the granted requester's done for exactly one cycle, then go to IDLE.
- Latency:
  - A pulse at edge t gives mem_req high in the cycle after edge t+1.
  - mem_ack at edge a gives done high in the cycle after edge a+1.
  - Back-to-back transactions have 2 idle cycles of mem_req between them.
  - A zero-wait memory (ack in the first mem_req cycle) gives 4 cycles from request pulse to done.
- Write completion: d_done pulses after a write ack; d_block is unchanged on writes.
- Mispredict:
  - Clears the I pending bit.
  - If an I transaction is in BUSY, sets the discard flag. That transaction still completes on memory, but i_block is not updated and i_done is suppressed; discard clears in RESP.
  - If mispredict and i_bread occur in the same cycle, mispredict wins and the request is dropped without setting overrun.
  - A new i_bread in the cycle after mispredict is accepted normally.
  - Mispredict does not affect D$ traffic.
- No timeout: the arbiter waits in BUSY indefinitely for mem_ack. An ack outside BUSY is ignored.
- Address alignment: mem_addr = {addr_lat[addr-1:ofst], ofst'b0}.

Decomposition:
- Shared package:
  - State encoding: IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2.
  - Requester ids: REQ_I = 1'b0, REQ_D = 1'b1.
  - Block width constant blck = 8<<ofst.
- One sub-module, arb_req_latch: holds the pending bit, latched address/data/kind and overrun detection for one requester. Instantiated twice; the I$ instance has its write path tied off.
- The FSM, round-robin and discard logic stay in the top module.

Test Plan:
- Single I read: i_bread with i_addr=0x0000_1234, ack after 3 cycles, mem_rdata=0xA5 repeated -> mem_addr=0x0000_1220, mem_we=0, one i_done pulse with i_block=0xA5.., d_done stays 0.
- Simultaneous i_bread and d_bread after reset -> D$ served first, then I$; next simultaneous pair -> I$ first.
- D write-back: d_bwrite with d_addr=0x8000_0040, d_wblock=0xDEAD.. -> mem_we=1 and mem_wdata held until ack; d_done pulses; d_block unchanged.
- Mispredict during I BUSY -> memory ack still consumed, no i_done, i_block keeps its old value; the following i_bread is served normally.
- Repeat i_bread while an I request is pending -> overrun=1 and stays 1; exactly one memory transaction is issued.
- RESET low mid-BUSY -> mem_req=0 and state IDLE immediately; a subsequent mem_ack is ignored with no done pulse.
